master_cmd_queue: RTL and testbench
===================================

Name: master_cmd_queue

Overview:
- Command sequencer directly upstream of master_port. Buffers bus commands (read/write, slave id, address, data, burst) in a small FIFO.
- Drives master_port's user-side inputs for one command at a time and holds approval_grant through the transaction.
- Returns read beats on a response stream and flags watchdog timeouts.
- One instance per master (m1, m2) in the bus top level.

Parameters:
- ADDR_WIDTH, 12: address field width.
- DATA_WIDTH, 8: write and read data width.
- BURST_WIDTH, 4: burst count width.
- SLAVE_SEL_WIDTH, 2: slave id width (1..3 valid).
- DEPTH, 4: command FIFO entries, power of two, ≥2.
- TIMEOUT, 1023: watchdog limit in cycles per transaction.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (not full).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_slave  in  SLAVE_SEL_WIDTH  target slave.
- cmd_address  in  ADDR_WIDTH  start address.
- cmd_data  in  DATA_WIDTH  write data.
- cmd_burst  in  BURST_WIDTH  beats; 0 treated as 1.
- instruction  out  1  to master_port; 1 = write.
- slave_select  out  SLAVE_SEL_WIDTH  to master_port.
- address  out  ADDR_WIDTH  to master_port.
- data  out  DATA_WIDTH  to master_port.
- burst_num  out  BURST_WIDTH  to master_port.
- approval_grant  out  1  request/hold to master_port (and on to the arbiter).
- tx_done  in  1  master_port transmit-complete pulse.
- new_rx  in  1  master_port read-beat pulse.
- rx_data  in  DATA_WIDTH  read beat data, valid with new_rx.
- rsp_valid  out  1  one-cycle read-beat pulse.
- rsp_data  out  DATA_WIDTH  read beat data.
- rsp_last  out  1  final beat of a read, with rsp_valid.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- idle  out  1  FIFO empty and FSM in IDLE.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): FIFO pointers 0, count=0, FSM=IDLE.
  - Outputs: approval_grant, rsp_valid, rsp_last, timeout_err = 0; all command fields = 0; cmd_ready=1; idle=1.
  - Reset mid-transaction drops approval_grant the next cycle and discards all queued commands.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only on DONE→IDLE or on timeout abort.
  - Push and pop in the same cycle keeps count unchanged and is legal when full.
  - A push while full with no pop is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, RD, DONE.
  - IDLE: if count>0, register head fields onto the outputs, assert approval_grant, go to REQ. One cycle of latency from head-valid to approval_grant.
  - REQ: approval_grant=1, output fields held stable. On tx_done:
    - write → DONE.
    - read → RD, beat counter = max(cmd_burst,1).
    - A new_rx in the same cycle as tx_done counts as the first beat.
  - RD: each new_rx emits rsp_valid with rsp_data=rx_data the following cycle (1-cycle latency) and decrements the beat counter. When the counter reaches 0, rsp_last=1 on that beat and go to DONE.
  - DONE: approval_grant=0 for exactly one cycle (release gap for the arbiter), pop the head, return to IDLE.
- Ignored inputs:
  - new_rx in IDLE, DONE, or REQ (except with tx_done) is ignored.
  - tx_done outside REQ is ignored.
- Watchdog:
  - Counter cleared on entry to REQ, increments each cycle in REQ/RD.
  - When it reaches TIMEOUT: pulse timeout_err, pop the command, drop approval_grant, go to IDLE (no DONE cycle).
  - No rsp_last is emitted for an aborted read.
- Back-to-back commands: minimum 2 idle-grant cycles (DONE + IDLE) between approval_grant deassert and the next assert.
- idle = (count==0) && state==IDLE.

Test Plan:
1. Single write: push {write=1, slave=2, addr=0x0A5, data=0x3C, burst=1}.
   - approval_grant rises 1 cycle after push, with slave_select=2 and address=0x0A5.
   - tx_done pulse at cycle 6 → approval_grant low at cycle 7; count goes 1→0; idle=1 at cycle 8.
2. Burst read: push {read, slave=1, addr=0x010, burst=3}; tx_done, then new_rx with rx_data 0x11, 0x22, 0x33.
   - Three rsp_valid pulses carrying 0x11, 0x22, 0x33, each 1 cycle after its new_rx.
   - rsp_last only with 0x33.
3. Full/wrap: push 5 commands with DEPTH=4.
   - cmd_ready=0 after the 4th; the 5th is held until the first DONE pop, then accepted.
   - count never exceeds 4; commands issue in order across the pointer wrap.
4. Burst 0 read: burst=0 with one new_rx coincident with tx_done → exactly one rsp_valid with rsp_last=1.
5. Timeout: TIMEOUT=20, read issued with no tx_done.
   - timeout_err pulses at cycle 20 after REQ entry; approval_grant drops; the next queued command issues normally.
6. Reset mid-read after 1 of 3 beats: next cycle approval_grant=0, count=0, idle=1, no further rsp_valid.

Source files
------------

// File: rtl/master_cmd_queue.sv
// master_cmd_queue: buffers bus commands and sequences them one at a
// time onto master_port, returning read beats and flagging timeouts.
module master_cmd_queue #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int BURST_WIDTH     = 4,
  parameter int SLAVE_SEL_WIDTH = 2,
  parameter int DEPTH           = 4,
  parameter int TIMEOUT         = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [SLAVE_SEL_WIDTH-1:0] cmd_slave,
  input  logic [ADDR_WIDTH-1:0]      cmd_address,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic [BURST_WIDTH-1:0]     cmd_burst,
  output logic                       instruction,
  output logic [SLAVE_SEL_WIDTH-1:0] slave_select,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic [DATA_WIDTH-1:0]      data,
  output logic [BURST_WIDTH-1:0]     burst_num,
  output logic                       approval_grant,
  input  logic                       tx_done,
  input  logic                       new_rx,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_last,
  output logic                       timeout_err,
  output logic                       idle,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                       write;
    logic [SLAVE_SEL_WIDTH-1:0] slave;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]      data;
    logic [BURST_WIDTH-1:0]     burst;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD,
    DONE
  } state_t;

  cmd_t                   mem [DEPTH];
  cmd_t                   head;
  cmd_t                   in_cmd;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          occ;
  state_t                 state;
  logic [WW-1:0]          wd;
  logic [BURST_WIDTH-1:0] beats;
  logic [BURST_WIDTH-1:0] first_beats;
  logic                   busy;
  logic                   wd_hit;
  logic                   full;
  logic                   push;
  logic                   pop;

  assign in_cmd = {cmd_write, cmd_slave, cmd_address,
                   cmd_data, cmd_burst};
  assign head   = mem[rd_ptr];
  assign full   = occ == CW'(DEPTH);
  assign busy   = (state == REQ) || (state == RD);
  assign wd_hit = busy && (wd == WW'(TIMEOUT - 1));
  // The head leaves the queue after its release cycle or on abort.
  assign pop    = (state == DONE) || wd_hit;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign cmd_ready = !full || pop;
  assign push   = cmd_valid && cmd_ready;
  assign count  = occ;
  assign idle   = (occ == '0) && (state == IDLE);

  assign first_beats = (burst_num == '0) ? BURST_WIDTH'(1) : burst_num;

  // Command storage; written on every accepted push.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Transaction sequencer with watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      approval_grant <= 1'b0;
      instruction    <= 1'b0;
      slave_select   <= '0;
      address        <= '0;
      data           <= '0;
      burst_num      <= '0;
      wd             <= '0;
      beats          <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_last       <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (occ != '0) begin
            {instruction, slave_select, address,
             data, burst_num} <= head;
            approval_grant    <= 1'b1;
            wd                <= '0;
            state             <= REQ;
          end
        end
        REQ: begin
          if (wd_hit) begin
            timeout_err    <= 1'b1;
            approval_grant <= 1'b0;
            state          <= IDLE;
          end else begin
            wd <= wd + 1'b1;
            if (tx_done) begin
              if (instruction) begin
                approval_grant <= 1'b0;
                state          <= DONE;
              end else if (new_rx) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rx_data;
                if (first_beats == BURST_WIDTH'(1)) begin
                  rsp_last       <= 1'b1;
                  approval_grant <= 1'b0;
                  state          <= DONE;
                end else begin
                  beats <= first_beats - 1'b1;
                  state <= RD;
                end
              end else begin
                beats <= first_beats;
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (wd_hit) begin
            timeout_err    <= 1'b1;
            approval_grant <= 1'b0;
            state          <= IDLE;
          end else begin
            wd <= wd + 1'b1;
            if (new_rx) begin
              rsp_valid <= 1'b1;
              rsp_data  <= rx_data;
              beats     <= beats - 1'b1;
              if (beats == BURST_WIDTH'(1)) begin
                rsp_last       <= 1'b1;
                approval_grant <= 1'b0;
                state          <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_cmd_queue.sv
// tb_master_cmd_queue: directed vectors, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_master_cmd_queue;

  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_slave = '0;
  logic [11:0] cmd_address = '0;
  logic [7:0]  cmd_data = '0;
  logic [3:0]  cmd_burst = '0;
  logic        tx_done = 1'b0;
  logic        new_rx = 1'b0;
  logic [7:0]  rx_data = '0;

  logic        cmd_ready;
  logic        instruction;
  logic [1:0]  slave_select;
  logic [11:0] address;
  logic [7:0]  data;
  logic [3:0]  burst_num;
  logic        approval_grant;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        timeout_err;
  logic        idle;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  master_cmd_queue #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8),
    .BURST_WIDTH(4),
    .SLAVE_SEL_WIDTH(2),
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_slave(cmd_slave),
    .cmd_address(cmd_address),
    .cmd_data(cmd_data),
    .cmd_burst(cmd_burst),
    .instruction(instruction),
    .slave_select(slave_select),
    .address(address),
    .data(data),
    .burst_num(burst_num),
    .approval_grant(approval_grant),
    .tx_done(tx_done),
    .new_rx(new_rx),
    .rx_data(rx_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .timeout_err(timeout_err),
    .idle(idle),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        w;
    logic [1:0]  s;
    logic [11:0] a;
    logic [7:0]  d;
    logic [3:0]  b;
  } cmd_t;

  cmd_t       mq[$];
  cmd_t       m_cur = '0;
  bit         m_hold = 0;
  bit         m_gap = 0;
  int         m_age = 0;
  int         m_beats = 0;
  bit         e_rv = 0;
  bit         e_rl = 0;
  bit         e_to = 0;
  logic [7:0] e_rd = '0;

  task automatic do_beat();
    e_rv = 1;
    e_rd = rx_data;
    m_beats--;
    if (m_beats == 0) begin
      e_rl   = 1;
      m_hold = 0;
      m_gap  = 1;
    end
  endtask

  always @(posedge clk) begin
    bit popn;
    bit acc;
    popn = m_gap || (m_hold && m_age == TO - 1);
    acc  = cmd_valid && (mq.size() < DEPTH || popn);
    e_rv = 0;
    e_rl = 0;
    e_to = 0;
    if (reset) begin
      mq.delete();
      m_hold = 0;
      m_gap  = 0;
      m_cur  = '0;
      m_age  = 0;
      m_beats = 0;
    end else begin
      if (m_hold) begin
        if (m_age == TO - 1) begin
          e_to   = 1;
          m_hold = 0;
        end else begin
          m_age++;
          if (m_beats < 0) begin
            if (tx_done) begin
              if (m_cur.w) begin
                m_hold = 0;
                m_gap  = 1;
              end else begin
                m_beats = (m_cur.b == 0) ? 1 : int'(m_cur.b);
                if (new_rx) do_beat();
              end
            end
          end else if (new_rx) begin
            do_beat();
          end
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (mq.size() > 0) begin
        m_hold  = 1;
        m_age   = 0;
        m_beats = -1;
        m_cur   = mq[0];
      end
      if (popn) void'(mq.pop_front());
      if (acc) mq.push_back({cmd_write, cmd_slave, cmd_address,
                             cmd_data, cmd_burst});
    end
  end

  // Every cycle, compare all DUT outputs against the model.
  always @(negedge clk) begin
    chk("m_grant", 32'(approval_grant), 32'(m_hold));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_idle", 32'(idle), 32'(mq.size() == 0 && !m_hold && !m_gap));
    chk("m_ready", 32'(cmd_ready),
        32'(mq.size() < DEPTH || m_gap || (m_hold && m_age == TO - 1)));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("m_rsp_last", 32'(rsp_last), 32'(e_rl));
    chk("m_timeout", 32'(timeout_err), 32'(e_to));
    if (e_rv) chk("m_rsp_data", 32'(rsp_data), 32'(e_rd));
    chk("m_fields", 32'({instruction, slave_select, address, burst_num}),
        32'({m_cur.w, m_cur.s, m_cur.a, m_cur.b}));
    chk("m_data", 32'(data), 32'(m_cur.d));
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic w, input logic [1:0] s,
                      input logic [11:0] a, input logic [7:0] d,
                      input logic [3:0] b);
    int k = 0;
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_slave   = s;
    cmd_address = a;
    cmd_data    = d;
    cmd_burst   = b;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("push_wait", 32'(k < 200), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_grant();
    int k = 0;
    while (!approval_grant && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("grant_wait", 32'(approval_grant), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!idle && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", 32'(idle), 1);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [11:0] a;
    logic [7:0]  d;
    logic [3:0]  b;
    bit          coin;
    int          nbeats;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int j;
    int n;

    tbl[0] = '{1'b1, 2'd3, 12'h7FF, 8'hA5, 4'd2, 1'b0, 0};
    tbl[1] = '{1'b0, 2'd1, 12'h010, 8'h00, 4'd3, 1'b0, 3};
    tbl[2] = '{1'b0, 2'd2, 12'h100, 8'h00, 4'd0, 1'b1, 1};
    tbl[3] = '{1'b0, 2'd3, 12'hFFF, 8'h00, 4'd2, 1'b1, 2};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(approval_grant), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_addr", 32'(address), 0);
    chk("rst_slave", 32'(slave_select), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_to", 32'(timeout_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // single write with exact timing
    push(1'b1, 2'd2, 12'h0A5, 8'h3C, 4'd1);
    chk("w_count1", 32'(count), 1);
    chk("w_grant_pre", 32'(approval_grant), 0);
    @(negedge clk);
    chk("w_grant", 32'(approval_grant), 1);
    chk("w_slave", 32'(slave_select), 2);
    chk("w_addr", 32'(address), 32'h0A5);
    chk("w_instr", 32'(instruction), 1);
    chk("w_data", 32'(data), 32'h3C);
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("w_release", 32'(approval_grant), 0);
    chk("w_count_done", 32'(count), 1);
    @(negedge clk);
    chk("w_count0", 32'(count), 0);
    chk("w_idle", 32'(idle), 1);

    // table-driven transactions
    foreach (tbl[i]) begin
      push(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].b);
      wait_grant();
      chk("v_instr", 32'(instruction), 32'(tbl[i].w));
      chk("v_slave", 32'(slave_select), 32'(tbl[i].s));
      chk("v_addr", 32'(address), 32'(tbl[i].a));
      chk("v_burst", 32'(burst_num), 32'(tbl[i].b));
      @(negedge clk);
      tx_done = 1'b1;
      new_rx  = tbl[i].coin;
      rx_data = 8'h11;
      @(negedge clk);
      tx_done = 1'b0;
      new_rx  = 1'b0;
      j = 0;
      if (tbl[i].coin) begin
        chk("v_rv0", 32'(rsp_valid), 1);
        chk("v_rd0", 32'(rsp_data), 32'h11);
        chk("v_rl0", 32'(rsp_last), 32'(tbl[i].nbeats == 1));
        j = 1;
      end else begin
        chk("v_norsp", 32'(rsp_valid), 0);
      end
      while (j < tbl[i].nbeats) begin
        new_rx  = 1'b1;
        rx_data = 8'(8'h11 * (j + 1));
        @(negedge clk);
        new_rx = 1'b0;
        chk("v_rv", 32'(rsp_valid), 1);
        chk("v_rd", 32'(rsp_data), 32'(8'(8'h11 * (j + 1))));
        chk("v_rl", 32'(rsp_last), 32'(j == tbl[i].nbeats - 1));
        j++;
      end
      chk("v_release", 32'(approval_grant), 0);
      @(negedge clk);
      chk("v_rsp_end", 32'(rsp_valid), 0);
      wait_idle();
    end

    // full queue and pointer wrap
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 2'(i % 3 + 1), 12'(12'h200 + i), 8'(i), 4'd1);
    end
    chk("f_count", 32'(count), 4);
    chk("f_ready", 32'(cmd_ready), 0);
    fork
      push(1'b1, 2'd1, 12'h204, 8'h04, 4'd1);
      for (int i = 0; i < 5; i++) begin
        wait_grant();
        chk("f_order", 32'(address), 32'(12'h200 + i));
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    join
    wait_idle();

    // watchdog abort, then the next command proceeds
    push(1'b0, 2'd1, 12'h321, 8'h00, 4'd2);
    push(1'b1, 2'd3, 12'h654, 8'h77, 4'd1);
    wait_grant();
    n = 0;
    while (!timeout_err && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_grant", 32'(approval_grant), 0);
    chk("to_count", 32'(count), 1);
    chk("to_nolast", 32'(rsp_last), 0);
    @(negedge clk);
    chk("to_next_grant", 32'(approval_grant), 1);
    chk("to_next_addr", 32'(address), 32'h654);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_idle();

    // reset in the middle of a burst read
    push(1'b0, 2'd1, 12'h010, 8'h00, 4'd3);
    push(1'b1, 2'd2, 12'h0AA, 8'h55, 4'd1);
    wait_grant();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    new_rx  = 1'b1;
    rx_data = 8'h11;
    @(negedge clk);
    new_rx = 1'b0;
    chk("r_beat1", 32'(rsp_valid), 1);
    reset   = 1'b1;
    new_rx  = 1'b1;
    rx_data = 8'h22;
    @(negedge clk);
    new_rx = 1'b0;
    reset  = 1'b0;
    chk("r_grant", 32'(approval_grant), 0);
    chk("r_count", 32'(count), 0);
    chk("r_idle", 32'(idle), 1);
    chk("r_rsp", 32'(rsp_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("r_quiet", 32'(rsp_valid), 0);
      chk("r_nogrant", 32'(approval_grant), 0);
    end

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      cmd_valid   = ($urandom_range(0, 2) == 0);
      cmd_write   = 1'($urandom_range(0, 1));
      cmd_slave   = 2'($urandom_range(1, 3));
      cmd_address = 12'($urandom);
      cmd_data    = 8'($urandom);
      cmd_burst   = 4'($urandom_range(0, 3));
      tx_done     = ($urandom_range(0, 3) == 0);
      new_rx      = 1'($urandom_range(0, 1));
      rx_data     = 8'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    tx_done   = 1'b0;
    new_rx    = 1'b0;
    reset     = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
